fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues in-order requests to instruction memory, and buffers responses in a small queue.

---
 rtl/fetch_unit.sv | 219 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the fetch PC, issues in-order word requests to
//   instruction memory, buffers the returned words with their PCs in a small
//   queue, and hands the queue head to decode over a valid/ready handshake.
//   A redirect from execute (branch_taken + branch_target) clears the queue
//   and discards every response that is still in flight.
//
//   Optional feature: define FETCH_PERF_EN to add three saturating
//   performance counters (perf_fetched, perf_flushed, perf_stall).
//
// Parameters
//   QUEUE_DEPTH      instruction queue entries (power of 2, >= 2)
//   MAX_OUTSTANDING  max requests accepted by memory but not yet answered
//   RESET_PC         first fetch address after reset
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   imem_req / imem_addr      fetch request and word-aligned address
//   imem_ready                memory accepts the request this cycle
//   imem_rsp_valid / _data    in-order response from memory
//   branch_taken / _target    single-cycle redirect from execute
//   insn_valid / insn_ready   queue head handshake toward decode
//   insn_out / pc_out         queue head instruction and its PC
//   perf_* (FETCH_PERF_EN)    fetched / flushed / stall-cycle counters
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned QUEUE_DEPTH     = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h8002_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [31:0] insn_out,
   output logic [31:0] pc_out
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed,
   output logic [31:0] perf_stall
`endif
);

   localparam int unsigned QAW = $clog2(QUEUE_DEPTH);
   localparam int unsigned QCW = QAW + 1;
   localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t         state;
   logic [31:0]    fetch_pc;
   logic [OCW-1:0] outstanding;   // live requests whose responses will be enqueued
   logic [OCW-1:0] drop_cnt;      // responses still to be thrown away after a redirect

   // Per-request PC FIFO: one entry per outstanding request, oldest at pf_rd.
   logic [31:0]    pc_fifo [MAX_OUTSTANDING];
   logic [PAW-1:0] pf_wr, pf_rd;

   // Instruction queue.
   logic [31:0]    q_pc   [QUEUE_DEPTH];
   logic [31:0]    q_insn [QUEUE_DEPTH];
   logic [QAW-1:0] q_wr, q_rd;
   logic [QCW-1:0] q_cnt;

   logic           credit, accept, rsp_run, rsp_drain, push, pop;
   logic [OCW-1:0] drop_next;
   logic           unused_target_bits;

   assign unused_target_bits = ^branch_target[1:0];

   function automatic logic [PAW-1:0] pf_next(input logic [PAW-1:0] p);
      return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PAW'(1);
   endfunction

   // Every accepted request reserves a queue slot, so a response can never
   // find the queue full; the request is held once raised because pops and
   // responses only ever free credit.
   assign credit    = (32'(q_cnt) + 32'(outstanding) < QUEUE_DEPTH) &&
                      (32'(outstanding) < MAX_OUTSTANDING);
   assign imem_req  = (state == RUN) && credit;
   assign imem_addr = fetch_pc;
   assign accept    = imem_req && imem_ready;

   // Responses only count when something is expected; stray ones are ignored.
   assign rsp_run   = imem_rsp_valid && (state == RUN)   && (outstanding != '0);
   assign rsp_drain = imem_rsp_valid && (state == DRAIN) && (drop_cnt != '0);
   assign push      = rsp_run && !branch_taken;
   assign pop       = insn_valid && insn_ready;

   // Responses still owed by memory after this cycle, used when redirecting:
   // in RUN everything in flight (including a request accepted right now)
   // becomes garbage; in DRAIN the existing count keeps running down.
   always_comb begin
      drop_next = '0;
      if (state == DRAIN)
         drop_next = drop_cnt - OCW'(rsp_drain);
      else if (state == RUN)
         drop_next = outstanding + OCW'(accept) - OCW'(rsp_run);
   end

   // ---------------------------------------------------------------- control
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         pf_wr       <= '0;
         pf_rd       <= '0;
      end else if (branch_taken) begin
         fetch_pc    <= {branch_target[31:2], 2'b00};
         outstanding <= '0;
         pf_wr       <= '0;
         pf_rd       <= '0;
         drop_cnt    <= drop_next;
         state       <= (drop_next != '0) ? DRAIN : RUN;
      end else begin
         case (state)
            IDLE: state <= RUN;
            RUN: begin
               if (accept) begin
                  fetch_pc <= fetch_pc + 32'd4;
                  pf_wr    <= pf_next(pf_wr);
               end
               if (rsp_run)
                  pf_rd <= pf_next(pf_rd);
               outstanding <= outstanding + OCW'(accept) - OCW'(rsp_run);
            end
            DRAIN: begin
               drop_cnt <= drop_next;
               if (drop_next == '0)
                  state <= RUN;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (accept)
         pc_fifo[pf_wr] <= fetch_pc;
   end

   // ---------------------------------------------------------------- queue
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q_wr  <= '0;
         q_rd  <= '0;
         q_cnt <= '0;
      end else if (branch_taken) begin
         q_wr  <= '0;
         q_rd  <= '0;
         q_cnt <= '0;
      end else begin
         if (push) q_wr <= q_wr + QAW'(1);
         if (pop)  q_rd <= q_rd + QAW'(1);
         q_cnt <= q_cnt + QCW'(push) - QCW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         q_pc[q_wr]   <= pc_fifo[pf_rd];
         q_insn[q_wr] <= imem_rsp_data;
      end
   end

   // Head is forced to zero while empty so decode never sees stale storage.
   assign insn_valid = (q_cnt != '0);
   assign insn_out   = insn_valid ? q_insn[q_rd] : 32'd0;
   assign pc_out     = insn_valid ? q_pc[q_rd]   : 32'd0;

   a_no_push_on_full: assert property (@(posedge clock) disable iff (!reset_n)
      !(push && q_cnt == QCW'(QUEUE_DEPTH)));

`ifdef FETCH_PERF_EN
   // ---------------------------------------------------------------- perf
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // Flushed work: entries wiped from the queue (minus one popped in the same
   // cycle) plus every response thrown away, whether in the redirect cycle
   // itself or later while draining.
   logic [31:0] flush_amt;
   always_comb begin
      flush_amt = 32'd0;
      if (branch_taken)
         flush_amt = 32'(q_cnt) - 32'(pop) + 32'(rsp_run);
      if (rsp_drain)
         flush_amt = flush_amt + 32'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched <= 32'd0;
         perf_flushed <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         perf_fetched <= sat_add(perf_fetched, 32'(push));
         perf_flushed <= sat_add(perf_flushed, flush_amt);
         perf_stall   <= sat_add(perf_stall, 32'((state == RUN) && !accept));
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Randomised bench for fetch_unit. A memory model answers accepted requests
//   in order after a random delay with a word derived from the address. The
//   reference model only knows the architectural stream: decode must see
//   consecutive PCs starting at RESET_PC or at the latest aligned redirect
//   target, each paired with the word memory holds at that PC.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h8002_0000;
   localparam int QD = 4;
   localparam int MO = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        insn_valid;
   logic        insn_ready = 1'b0;
   logic [31:0] insn_out;
   logic [31:0] pc_out;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

   always #5 clock = ~clock;

   fetch_unit #(.QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO), .RESET_PC(RESET_PC)) dut (
      .clock(clock), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .insn_valid(insn_valid), .insn_ready(insn_ready),
      .insn_out(insn_out), .pc_out(pc_out)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] pend[$];            // addresses accepted by memory, not yet answered
   logic [31:0] acc_log[$], dlv_log[$];
   logic [31:0] exp_pc, exp_addr, hold_addr, force_tgt;
   logic        hold_chk, expect_empty, force_br;
   int          rdy_pct, rsp_pct, ird_pct, br_pml;
   int          n_acc, n_dlv;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare DUT outputs against the stream model for the edge about to come.
   task automatic observe();
      if (expect_empty) chk("insn_valid after redirect", 32'(insn_valid), 32'd0);
      expect_empty = 1'b0;
      if (hold_chk) begin
         chk("req held", 32'(imem_req), 32'd1);
         chk("addr held", imem_addr, hold_addr);
      end
      if (insn_valid && insn_ready) begin
         chk("pc_out", pc_out, exp_pc);
         chk("insn_out", insn_out, mem_word(exp_pc));
         dlv_log.push_back(pc_out);
         exp_pc = exp_pc + 32'd4;
         n_dlv++;
      end
      if (imem_req && imem_ready) begin
         chk("imem_addr", imem_addr, exp_addr);
         chk("in-flight bound", 32'(pend.size() < MO), 32'd1);
         pend.push_back(imem_addr);
         acc_log.push_back(imem_addr);
         exp_addr = exp_addr + 32'd4;
         n_acc++;
      end
      hold_chk  = imem_req && !imem_ready && !branch_taken;
      hold_addr = imem_addr;
      if (branch_taken) begin
         exp_pc       = branch_target & ~32'd3;
         exp_addr     = exp_pc;
         expect_empty = 1'b1;
         acc_log.delete();
         dlv_log.delete();
      end
   endtask

   task automatic step();
      @(negedge clock);
      imem_ready = ($urandom_range(99) < rdy_pct);
      if (pend.size() > 0 && $urandom_range(99) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      insn_ready = ($urandom_range(99) < ird_pct);
      if (force_br) begin
         branch_taken  = 1'b1;
         branch_target = force_tgt;
         force_br      = 1'b0;
      end else if ($urandom_range(999) < br_pml) begin
         branch_taken  = 1'b1;
         branch_target = RESET_PC + ($urandom_range(1023) << 2) + $urandom_range(3);
      end else begin
         branch_taken  = 1'b0;
         branch_target = $urandom;
      end
      #1;
      observe();
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      imem_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
      insn_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
      #1;
      chk("rst imem_req", 32'(imem_req), 32'd0);
      chk("rst imem_addr", imem_addr, RESET_PC);
      chk("rst insn_valid", 32'(insn_valid), 32'd0);
      chk("rst insn_out", insn_out, 32'd0);
      chk("rst pc_out", pc_out, 32'd0);
`ifdef FETCH_PERF_EN
      chk("rst perf_flushed", perf_flushed, 32'd0);
`endif
      pend.delete(); acc_log.delete(); dlv_log.delete();
      exp_pc = RESET_PC; exp_addr = RESET_PC;
      hold_chk = 1'b0; expect_empty = 1'b0; force_br = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic knobs(input int r, input int s, input int i, input int b);
      rdy_pct = r; rsp_pct = s; ird_pct = i; br_pml = b;
   endtask

   initial begin
      int d0;
`ifdef FETCH_PERF_EN
      logic [31:0] fl0;
`endif
      n_acc = 0; n_dlv = 0; force_br = 1'b0; force_tgt = 32'd0;
      knobs(100, 100, 100, 0);

      // Streaming: one instruction per cycle once filled.
      do_reset();
      repeat (5) step();
      d0 = n_dlv;
      repeat (10) step();
      chk("s1 throughput", 32'(n_dlv - d0), 32'd10);
      chk("s1 pc0", dlv_log[0], 32'h8002_0000);
      chk("s1 pc1", dlv_log[1], 32'h8002_0004);
      chk("s1 pc2", dlv_log[2], 32'h8002_0008);

      // Decode stalled: exactly QUEUE_DEPTH requests, then drain in order.
      do_reset();
      knobs(100, 100, 0, 0);
      n_acc = 0;
      repeat (10) step();
      chk("s2 requests", 32'(n_acc), 32'd4);
      chk("s2 req low", 32'(imem_req), 32'd0);
      chk("s2 head valid", 32'(insn_valid), 32'd1);
      knobs(100, 100, 100, 0);
      repeat (8) step();
      chk("s2 drained", 32'(dlv_log.size() >= 4), 32'd1);
      if (dlv_log.size() >= 4)
         for (int i = 0; i < 4; i++)
            chk("s2 order", dlv_log[i], RESET_PC + 32'(4 * i));

      // Redirect with two responses in flight.
      do_reset();
      knobs(100, 0, 100, 0);
      repeat (4) step();
      chk("s3 in flight", 32'(pend.size()), 32'd2);
`ifdef FETCH_PERF_EN
      fl0 = perf_flushed;
`endif
      knobs(0, 0, 100, 0);
      force_br = 1'b1; force_tgt = 32'h8002_0100;
      step();
      knobs(100, 100, 100, 0);
      step();
      chk("s3 drain req", 32'(imem_req), 32'd0);
      repeat (8) step();
      chk("s3 first addr", acc_log[0], 32'h8002_0100);
      chk("s3 first pc", dlv_log[0], 32'h8002_0100);
`ifdef FETCH_PERF_EN
      chk("s3 perf_flushed", perf_flushed - fl0, 32'd2);
`endif

      // Redirect coinciding with an accepted request and a response.
      repeat (4) step();
      force_br = 1'b1; force_tgt = 32'h8002_0200;
      step();
      step();
      chk("s4 drain req", 32'(imem_req), 32'd0);
      repeat (6) step();
      chk("s4 first pc", dlv_log[0], 32'h8002_0200);

      // Unaligned target near the top of memory, memory stalled, then wrap.
      repeat (3) step();
      force_br = 1'b1; force_tgt = 32'hFFFF_FFFE;
      step();
      knobs(0, 100, 100, 0);
      repeat (6) step();
      chk("s5 stalled addr", imem_addr, 32'hFFFF_FFFC);
      chk("s5 stalled req", 32'(imem_req), 32'd1);
      knobs(100, 100, 100, 0);
      repeat (6) step();
      chk("s5 addr0", acc_log[0], 32'hFFFF_FFFC);
      chk("s5 addr1 wrap", acc_log[1], 32'h0000_0000);
      chk("s5 pc1 wrap", dlv_log[1], 32'h0000_0000);

      // Reset in the middle of a burst (reset values checked inside).
      do_reset();
      knobs(100, 100, 100, 0);
      repeat (6) step();
      do_reset();

      // Random traffic with occasional redirects and one mid-run reset.
      d0 = n_dlv;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0)
            knobs($urandom_range(100, 30), $urandom_range(100, 30),
                  $urandom_range(100, 20), $urandom_range(40));
         if (i == 1500) do_reset();
         step();
      end
      chk("random liveness", 32'(n_dlv - d0 > 300), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
